fifo_write_arbiter: RTL

// Round-robin arbiter sharing one gp_fifo write port among NUM_REQ requesters (cores/NoC input ports).

---
 rtl/fifo_write_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one gp_fifo write port among NUM_REQ requesters,
// with watermark hysteresis on FIFO occupancy to throttle writers before the FIFO fills.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 34,
    parameter int HIGH_WATER = 28,
    parameter int LOW_WATER  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      fifo_full,
    input  logic [4:0]                fifo_ocup,
    output logic [2:0]                grant_id,
    output logic                      throttle,
    output logic                      overflow_err
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_THROTTLE = 1'b1
    } state_t;

    localparam logic [5:0] HIGH_OCC = 6'(HIGH_WATER);
    localparam logic [5:0] LOW_OCC  = 6'(LOW_WATER);
    localparam logic [3:0] NUM_REQ4 = 4'(NUM_REQ);
    localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [2:0]               rr_ptr_r;
    logic [2:0]               grant_id_r;
    logic                     overflow_r;
    logic [5:0]               occ_s;
    logic [2*NUM_REQ-1:0]     req_dbl_s;
    logic [NUM_REQ-1:0]       req_rot_s;
    logic                     found_s;
    logic [2:0]               offset_s;
    logic [3:0]               winner_sum_s;
    logic [2:0]               winner_s;
    logic                     grant_ok_s;
    logic                     grant_s;

    // ocup wraps to 0 at 32 entries, so the full flag restores the true count
    assign occ_s = fifo_full ? 6'd32 : {1'b0, fifo_ocup};

    // Next-state logic for the watermark hysteresis
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (occ_s >= HIGH_OCC) begin
                    state_next_s = ST_THROTTLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_THROTTLE: begin
                if (occ_s <= LOW_OCC) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_THROTTLE;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Rotate requests so bit 0 is the requester at rr_ptr
    assign req_dbl_s = {req, req} >> rr_ptr_r;
    assign req_rot_s = req_dbl_s[NUM_REQ-1:0];
    assign found_s   = |req_rot_s;

    // Priority-encode the rotated vector: lowest set bit wins
    always_comb begin
        offset_s = 3'd0;
        for (int p = NUM_REQ - 1; p >= 0; p--) begin
            if (req_rot_s[p]) begin
                offset_s = 3'(p);
            end else begin
                offset_s = offset_s;
            end
        end
    end

    // Map the rotated offset back to an absolute requester index
    always_comb begin
        winner_sum_s = {1'b0, rr_ptr_r} + {1'b0, offset_s};
        if (winner_sum_s >= NUM_REQ4) begin
            winner_sum_s = winner_sum_s - NUM_REQ4;
        end else begin
            winner_sum_s = winner_sum_s;
        end
        winner_s = winner_sum_s[2:0];
    end

    // Reset gating keeps ack low immediately while reset is held
    assign grant_ok_s = !reset && (state_r == ST_RUN) && !fifo_full;
    assign grant_s    = grant_ok_s && found_s;

    // Drive the FIFO write port and the one-hot ack from the winner
    always_comb begin
        ack           = '0;
        fifo_write_en = grant_s;
        fifo_data_in  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s && (winner_s == 3'(i))) begin
                ack[i]       = 1'b1;
                fifo_data_in = wdata[i*DATA_W +: DATA_W];
            end else begin
                ack[i] = 1'b0;
            end
        end
    end

    // State, round-robin pointer, last grant and sticky overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            rr_ptr_r   <= 3'd0;
            grant_id_r <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                rr_ptr_r   <= (winner_s == LAST_REQ) ? 3'd0 : winner_s + 3'd1;
                grant_id_r <= winner_s;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                grant_id_r <= grant_id_r;
            end
            if (fifo_write_en && fifo_full) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign throttle     = (state_r == ST_THROTTLE);
    assign grant_id     = grant_id_r;
    assign overflow_err = overflow_r;

endmodule
